// File: rtl/pong_game_ctrl_if.sv
// Handshake bundle between the pong physics/graphics stage and the game-flow controller.
// The slave side is the controller. The master side is whoever drives the flags and reads the scores.
interface pong_game_ctrl_if;
    logic       start;
    logic       hit;
    logic       miss;
    logic       miss2;
    logic       gra_still;
    logic [7:0] score_1;
    logic [7:0] score_2;
    logic [7:0] rally;
    logic       game_over;
    logic       winner;

    modport master (
        output start, hit, miss, miss2,
        input  gra_still, score_1, score_2, rally, game_over, winner
    );

    modport slave (
        input  start, hit, miss, miss2,
        output gra_still, score_1, score_2, rally, game_over, winner
    );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game-flow controller: BCD scoring, rally count, serve delay and game-over/winner state.
// It freezes the ball through gra_still everywhere except during live play.
module pong_game_ctrl #(
    parameter int unsigned SERVE_DELAY = 100_000_000,
    parameter int unsigned WIN_SCORE   = 7
) (
    input  logic              clock,
    input  logic              reset,
    pong_game_ctrl_if.slave   bus
);

    localparam int unsigned TW = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(SERVE_DELAY - 1);
    localparam logic [6:0]    WIN_BIN    = 7'(WIN_SCORE);

    typedef enum logic [1:0] {IDLE, PLAY, SERVE, OVER} state_t;

    state_t        state, state_next;
    logic [TW-1:0] timer;
    logic          start_q, start_armed, hit_q;
    logic [6:0]    bin_1, bin_2;
    logic          start_rise, hit_rise;
    logic          point_1, point_2, win, rally_inc, rally_clr, new_game;

    // A start held high through reset release must be let go once before it counts.
    assign start_rise = bus.start & ~start_q & start_armed;
    assign hit_rise   = bus.hit & ~hit_q;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        point_1    = 1'b0;
        point_2    = 1'b0;
        win        = 1'b0;
        rally_inc  = 1'b0;
        rally_clr  = 1'b0;
        new_game   = 1'b0;
        case (state)
            IDLE: if (start_rise) state_next = PLAY;
            PLAY: begin
                if (bus.miss) begin
                    point_1 = 1'b1;
                    win     = (bin_1 + 7'd1) == WIN_BIN;
                end else if (bus.miss2) begin
                    point_2 = 1'b1;
                    win     = (bin_2 + 7'd1) == WIN_BIN;
                end else if (hit_rise) begin
                    rally_inc = 1'b1;
                end
                if (point_1 || point_2) state_next = win ? OVER : SERVE;
            end
            SERVE: if (timer == TIMER_LAST) begin
                state_next = PLAY;
                rally_clr  = 1'b1;
            end
            OVER: if (start_rise) begin
                new_game   = 1'b1;
                state_next = PLAY;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            start_q       <= 1'b0;
            start_armed   <= 1'b0;
            hit_q         <= 1'b0;
            timer         <= '0;
            bin_1         <= '0;
            bin_2         <= '0;
            bus.score_1   <= 8'h00;
            bus.score_2   <= 8'h00;
            bus.rally     <= 8'd0;
            bus.winner    <= 1'b0;
            bus.gra_still <= 1'b1;
            bus.game_over <= 1'b0;
        end else begin
            start_q <= bus.start;
            hit_q   <= bus.hit;
            if (!bus.start) start_armed <= 1'b1;

            // Counts only while staying in SERVE, so every entry starts from zero.
            timer <= (state == SERVE && state_next == SERVE) ? timer + 1'b1 : '0;

            if (new_game) begin
                bin_1       <= '0;
                bin_2       <= '0;
                bus.score_1 <= 8'h00;
                bus.score_2 <= 8'h00;
                bus.winner  <= 1'b0;
            end else begin
                if (point_1) begin
                    bin_1       <= bin_1 + 7'd1;
                    bus.score_1 <= bcd_inc(bus.score_1);
                end
                if (point_2) begin
                    bin_2       <= bin_2 + 7'd1;
                    bus.score_2 <= bcd_inc(bus.score_2);
                end
                if (win) bus.winner <= point_2;
            end

            if (rally_clr || new_game)
                bus.rally <= 8'd0;
            else if (rally_inc && bus.rally != 8'hFF)
                bus.rally <= bus.rally + 8'd1;

            bus.gra_still <= (state_next != PLAY);
            bus.game_over <= (state_next == OVER);
        end
    end

endmodule
